// File: rtl/seq_bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_pkg
// Shared definitions for the bit serializer that feeds the Mealy sequence
// detector: FSM state encoding and the default word width (also used by the
// detector bench).
// -----------------------------------------------------------------------------
package seq_bit_serializer_pkg;

   // Default word length shared with the downstream detector bench.
   localparam int SEQ_WIDTH = 20;

   // Serializer FSM states.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // Pick the bit that leaves the word first for the chosen shift order.
   function automatic logic first_bit(input logic lsb, input logic msb, input bit msb_first);
      logic b;
      if (msb_first) begin
         b = msb;
      end else begin
         b = lsb;
      end
      return b;
   endfunction

endpackage : seq_bit_serializer_pkg

// File: rtl/seq_bit_serializer_chk.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer_chk
// Simulation checker for the serializer bit counter: the counter must never
// reach WIDTH or beyond.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   active-low reset; checking is suspended while low
//   count  in   bit counter of the serializer
// -----------------------------------------------------------------------------
module seq_bit_serializer_chk #(
   parameter int WIDTH = 20,
   parameter int CNT_W = 5
) (
   input logic             clock,
   input logic             reset,
   input logic [CNT_W-1:0] count
);

   a_count_in_range : assert property (@(posedge clock) disable iff (!reset)
      (int'(count) < WIDTH))
      else $error("serializer bit counter out of range: %0d", count);

endmodule : seq_bit_serializer_chk

// File: rtl/seq_bit_serializer_piso_shift_reg.sv
// -----------------------------------------------------------------------------
// piso_shift_reg
// Parallel-in / serial-out data register with zero fill.
// The register always holds the bits that have NOT yet been presented, so a
// load stores the word already advanced by one position and sout offers the
// bit that the owner should present on the following cycle.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset (clears the register)
//   load   in   capture din (takes priority over shift)
//   shift  in   advance the register by one bit, vacated bit filled with 0
//   din    in   WIDTH-bit word to capture
//   sout   out  next bit to present: first bit of din on load, else head of register
// -----------------------------------------------------------------------------
module piso_shift_reg
   import seq_bit_serializer_pkg::*;
#(
   parameter int WIDTH     = SEQ_WIDTH,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             sout
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] src_s;
   logic [WIDTH-1:0] adv_s;

   // Select the word being consumed, advance it one bit and pick the outgoing bit.
   always_comb begin
      if (load) begin
         src_s = din;
      end else begin
         src_s = data_q;
      end

      if (MSB_FIRST) begin
         adv_s = {src_s[WIDTH-2:0], 1'b0};
      end else begin
         adv_s = {1'b0, src_s[WIDTH-1:1]};
      end

      sout = first_bit(src_s[0], src_s[WIDTH-1], MSB_FIRST);

      if (load || shift) begin
         data_d = adv_s;
      end else begin
         data_d = data_q;
      end
   end

   // Data register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_q <= {WIDTH{1'b0}};
      end else begin
         data_q <= data_d;
      end
   end

endmodule : piso_shift_reg

// File: rtl/seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// seq_bit_serializer
// Parallel-to-serial stimulus stage in front of the Mealy sequence detector.
// Accepts a WIDTH-bit word over valid/ready and presents it one bit per clock
// on x/x_valid. Words stream back-to-back when a new word is accepted during
// the last-bit cycle.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   load_valid  in   load_data is valid this cycle
//   load_ready  out  word can be accepted this cycle (combinational)
//   load_data   in   word to serialize
//   abort       in   synchronous cancel of the word in flight
//   x           out  serial bit (0 when x_valid is 0), registered
//   x_valid     out  x carries a payload bit, registered
//   busy        out  a word is in flight, registered
//   done        out  pulse while the last bit is on x, registered
// -----------------------------------------------------------------------------
module seq_bit_serializer
   import seq_bit_serializer_pkg::*;
#(
   parameter int WIDTH     = SEQ_WIDTH,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic             abort,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             x_q;
   logic             x_d;
   logic             done_q;
   logic             done_d;

   logic             last_s;
   logic             accept_s;
   logic             shift_s;
   logic             sout_s;

   // Handshake: ready in IDLE or on the last bit, always blocked by abort.
   always_comb begin
      last_s     = (state_q == ST_SHIFT) && (count_q == CNT_LAST);
      load_ready = !abort && ((state_q == ST_IDLE) || last_s);
      accept_s   = load_valid && load_ready;
      shift_s    = (state_q == ST_SHIFT) && !last_s && !abort;
   end

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_piso (
      .clock (clock),
      .reset (reset),
      .load  (accept_s),
      .shift (shift_s),
      .din   (load_data),
      .sout  (sout_s)
   );

   // FSM state and bit counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Next-state and next-count logic; count tracks the index of the bit on x.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (abort) begin
         state_d = ST_IDLE;
         count_d = CNT_ZERO;
      end else if (accept_s) begin
         state_d = ST_SHIFT;
         count_d = CNT_ZERO;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
               count_d = CNT_ZERO;
            end
            ST_SHIFT: begin
               if (!last_s) begin
                  state_d = ST_SHIFT;
                  count_d = count_q + CNT_ONE;
               end else begin
                  state_d = ST_IDLE;
                  count_d = CNT_ZERO;
               end
            end
            default: begin
               state_d = ST_IDLE;
               count_d = CNT_ZERO;
            end
         endcase
      end
   end

   // Output decode from the next state so x/done can be registered in step with it.
   always_comb begin
      x_d    = 1'b0;
      done_d = 1'b0;
      if (state_d == ST_SHIFT) begin
         x_d    = sout_s;
         done_d = (count_d == CNT_LAST);
      end else begin
         x_d    = 1'b0;
         done_d = 1'b0;
      end
   end

   // Output flops.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x_q    <= 1'b0;
         done_q <= 1'b0;
      end else begin
         x_q    <= x_d;
         done_q <= done_d;
      end
   end

   assign x       = x_q;
   assign done    = done_q;
   assign x_valid = (state_q == ST_SHIFT);
   assign busy    = (state_q == ST_SHIFT);

   seq_bit_serializer_chk #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_chk (
      .clock (clock),
      .reset (reset),
      .count (count_q)
   );

endmodule : seq_bit_serializer

// File: tb/tb_seq_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_bit_serializer
// Drives an LSB-first and an MSB-first serializer with identical handshake
// stimulus and compares both against a word/index reference model.
// -----------------------------------------------------------------------------
module tb_seq_bit_serializer;

   localparam int W = 20;

   logic         clock = 1'b0;
   logic         reset;
   logic         load_valid;
   logic [W-1:0] load_data;
   logic         abort;

   logic ready0, x0, xv0, busy0, done0;
   logic ready1, x1, xv1, busy1, done1;

   int checks = 0;
   int errors = 0;

   // Reference model: word in flight and index of the bit currently shown.
   bit           m_active = 1'b0;
   int           m_idx    = 0;
   logic [W-1:0] m_word   = '0;

   // Observation helpers.
   int           ncyc      = 0;
   int           done_cnt  = 0;
   int           last_done = 0;
   int           done_gap  = 0;
   logic [W-1:0] cap0      = '0;
   logic [W-1:0] cap1      = '0;

   always #5 clock = ~clock;

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (ready0),
      .load_data  (load_data),
      .abort      (abort),
      .x          (x0),
      .x_valid    (xv0),
      .busy       (busy0),
      .done       (done0)
   );

   seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
      .clock      (clock),
      .reset      (reset),
      .load_valid (load_valid),
      .load_ready (ready1),
      .load_data  (load_data),
      .abort      (abort),
      .x          (x1),
      .x_valid    (xv1),
      .busy       (busy1),
      .done       (done1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_x(input bit msb_first);
      if (!m_active) return 1'b0;
      if (msb_first) return m_word[W-1-m_idx];
      return m_word[m_idx];
   endfunction

   task automatic check_outs();
      logic exp_done;
      exp_done = m_active && (m_idx == W-1);
      chk("x_lsb",     x0,    exp_x(1'b0));
      chk("xv_lsb",    xv0,   m_active);
      chk("busy_lsb",  busy0, m_active);
      chk("done_lsb",  done0, exp_done);
      chk("x_msb",     x1,    exp_x(1'b1));
      chk("xv_msb",    xv1,   m_active);
      chk("busy_msb",  busy1, m_active);
      chk("done_msb",  done1, exp_done);
   endtask

   // One clock: apply inputs, check ready, step model at the edge, check outputs.
   task automatic cyc(input logic lv, input logic [W-1:0] d, input logic ab);
      logic exp_rdy;
      logic acc;
      load_valid = lv;
      load_data  = d;
      abort      = ab;
      #1;
      exp_rdy = !ab && (!m_active || (m_idx == W-1));
      chk("ready_lsb", ready0, exp_rdy);
      chk("ready_msb", ready1, exp_rdy);
      acc = lv && exp_rdy;
      @(posedge clock);
      if (ab) begin
         m_active = 1'b0;
      end else if (acc) begin
         m_word   = d;
         m_idx    = 0;
         m_active = 1'b1;
      end else if (m_active && m_idx < W-1) begin
         m_idx++;
      end else begin
         m_active = 1'b0;
      end
      #1;
      ncyc++;
      check_outs();
      cap0 = {x0, cap0[W-1:1]};
      cap1 = {x1, cap1[W-1:1]};
      if (done0) begin
         done_cnt++;
         done_gap  = ncyc - last_done;
         last_done = ncyc;
      end
   endtask

   initial begin
      reset      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      abort      = 1'b0;
      #12;
      // Reset state.
      check_outs();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Test 1: single word LSB first, exact bit pattern and done on bit 20.
      done_cnt = 0;
      cyc(1'b1, 20'hEB6DF, 1'b0);
      repeat (W-1) cyc(1'b0, '0, 1'b0);
      chk("t1_pattern", cap0, 20'hEB6DF);
      chk("t1_dones", done_cnt, 1);
      cyc(1'b0, '0, 1'b0);
      cyc(1'b0, '0, 1'b0);

      // Test 2: back-to-back words, accept during the last bit.
      done_cnt = 0;
      cyc(1'b1, 20'hEB6DF, 1'b0);
      repeat (W-1) cyc(1'b0, '0, 1'b0);
      cyc(1'b1, 20'h00001, 1'b0);
      repeat (W-1) cyc(1'b0, '0, 1'b0);
      chk("t2_pattern", cap0, 20'h00001);
      chk("t2_dones", done_cnt, 2);
      chk("t2_gap", done_gap, W);
      cyc(1'b0, '0, 1'b0);

      // Test 3: abort together with load_valid during bit 5.
      done_cnt = 0;
      cyc(1'b1, 20'hA5A5A, 1'b0);
      repeat (5) cyc(1'b0, '0, 1'b0);
      cyc(1'b1, 20'hFFFFF, 1'b1);
      repeat (W) cyc(1'b0, '0, 1'b0);
      chk("t3_no_done", done_cnt, 0);

      // Abort in IDLE only holds ready low.
      cyc(1'b1, 20'h12345, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // Test 4: load attempts mid-word are ignored.
      cyc(1'b1, 20'h00000, 1'b0);
      cyc(1'b0, '0, 1'b0);
      repeat (9) cyc(1'b1, 20'hFFFFF, 1'b0);
      repeat (W-11) cyc(1'b0, '0, 1'b0);
      chk("t4_zero_word", cap0, 20'h00000);
      cyc(1'b0, '0, 1'b0);

      // Test 5: asynchronous reset at bit 7, then a fresh word.
      cyc(1'b1, 20'h5F0F3, 1'b0);
      repeat (7) cyc(1'b0, '0, 1'b0);
      load_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("t5_x_async",    x0,    1'b0);
      chk("t5_xv_async",   xv0,   1'b0);
      chk("t5_busy_async", busy0, 1'b0);
      chk("t5_xv1_async",  xv1,   1'b0);
      m_active = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_outs();
      cyc(1'b1, 20'h3C96E, 1'b0);
      repeat (W-1) cyc(1'b0, '0, 1'b0);
      chk("t5_fresh", cap0, 20'h3C96E);
      cyc(1'b0, '0, 1'b0);

      // Test 6: MSB-first instance, 20'h80001 gives 1, 18 zeros, 1.
      cyc(1'b1, 20'h80001, 1'b0);
      repeat (W-1) cyc(1'b0, '0, 1'b0);
      chk("t6_msb_pattern", cap1, 20'h80001);
      chk("t6_done_last", done1, 1'b1);
      cyc(1'b0, '0, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic         lv;
         logic         ab;
         logic [W-1:0] d;
         lv = ($urandom_range(0, 3) != 0);
         ab = ($urandom_range(0, 15) == 0);
         d  = W'($urandom());
         cyc(lv, d, ab);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_seq_bit_serializer
